wallace_mult_pipe: RTL

WALLACE_MULT_PIPE -- requirements
Module: wallace_mult_pipe

---
 rtl/wallace_pkg.sv | 42 ++++
 rtl/wallace_cells.sv | 11 +
 rtl/wallace_mult_pipe_csa_row.sv | 27 ++
 rtl/wallace_mult_pipe.sv | 132 +++++++++++++
 4 files changed

// File: rtl/wallace_pkg.sv
// Shared types and elaboration-time helpers for the pipelined Wallace-tree multiplier.
// Row counts assume N partial-product rows plus one Baugh-Wooley correction row.
package wallace_pkg;

    typedef struct packed {
        logic valid;
        logic sgn;
    } stage_vs_t;

    // Rows left after lvl levels of 3:2 compression, starting from rows0 rows.
    function automatic int wal_rows(input int rows0, input int lvl);
        int r;
        r = rows0;
        for (int k = 0; k < lvl; k++) begin
            r = 2 * (r / 3) + r % 3;
        end
        return r;
    endfunction

    // Number of carry-save levels needed to reduce the N+1 row matrix to two rows.
    function automatic int wal_levels(input int n);
        int r;
        int l;
        r = n + 1;
        l = 0;
        while (r > 2) begin
            r = 2 * (r / 3) + r % 3;
            l++;
        end
        return l;
    endfunction

    // Baugh-Wooley correction: 2^N + 2^(2N-1), modulo 2^(2N).
    function automatic logic [31:0] bw_const(input int n);
        logic [31:0] c;
        c = '0;
        c[n] = 1'b1;
        c[2*n-1] = 1'b1;
        return c;
    endfunction

endpackage

// File: rtl/wallace_cells.sv
// Full-adder cell used by the carry-save rows.
module FA (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);
endmodule

// File: rtl/wallace_mult_pipe_csa_row.sv
// One 3:2 carry-save row of full adders; carries come out already shifted up one bit.
// The top bit keeps only its sum: its carry would fall beyond the 2N-bit result.
module csa_row #(
    parameter int W = 16
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic [W-1:0] z,
    output logic [W-1:0] s,
    output logic [W-1:0] c
);
    logic [W-2:0] w_co;
    logic [W-2:0] w_s;

    for (genvar k = 0; k < W - 1; k++) begin : g_fa
        FA u_fa (
            .a (x[k]),
            .b (y[k]),
            .ci(z[k]),
            .s (w_s[k]),
            .co(w_co[k])
        );
    end

    assign s = {x[W-1] ^ y[W-1] ^ z[W-1], w_s};
    assign c = {w_co, 1'b0};
endmodule

// File: rtl/wallace_mult_pipe.sv
// Three-stage valid/ready multiplier: S1 partial products, S2 Wallace reduction, S3 final add.
// Signed mode uses Baugh-Wooley so both modes share one unsigned reduction tree.
module wallace_mult_pipe
    import wallace_pkg::*;
#(
    parameter int N    = 8,
    parameter int TAGW = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N-1:0]    a,
    input  logic [N-1:0]    b,
    input  logic            sgn,
    input  logic [TAGW-1:0] in_tag,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [2*N-1:0]  p,
    output logic [TAGW-1:0] out_tag,
    output logic            out_sgn
);
    localparam int W    = 2 * N;
    localparam int ROWS = N + 1;
    localparam int LV   = wal_levels(N);
    localparam logic [31:0]  BW32 = bw_const(N);
    localparam logic [W-1:0] BW   = BW32[W-1:0];

    stage_vs_t       r_s1_vs, r_s2_vs, r_s3_vs;
    logic [TAGW-1:0] r_s1_tag, r_s2_tag, r_s3_tag;
    logic [W-1:0]    r_s1_pp [ROWS];
    logic [W-1:0]    r_s2_sum, r_s2_cry;
    logic [W-1:0]    r_s3_p;

    logic            w_adv1, w_adv2, w_adv3;
    logic [W-1:0]    w_pp [ROWS];
    logic [W-1:0]    w_lvl [LV+1][ROWS];

    // A stage may load when it is empty or its contents move on this cycle.
    assign w_adv3   = !r_s3_vs.valid || out_ready;
    assign w_adv2   = !r_s2_vs.valid || w_adv3;
    assign w_adv1   = !r_s1_vs.valid || w_adv2;
    assign in_ready = w_adv1;

    assign out_valid = r_s3_vs.valid;
    assign out_sgn   = r_s3_vs.sgn;
    assign out_tag   = r_s3_tag;
    assign p         = r_s3_p;

    always_comb begin
        for (int i = 0; i < ROWS; i++) begin
            w_pp[i] = '0;
        end
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                w_pp[i][i+j] = (a[j] & b[i]) ^ (sgn & ((i == N - 1) != (j == N - 1)));
            end
        end
        w_pp[N] = sgn ? BW : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_vs  <= '0;
            r_s1_tag <= '0;
            for (int i = 0; i < ROWS; i++) begin
                r_s1_pp[i] <= '0;
            end
        end else if (w_adv1) begin
            r_s1_vs.valid <= in_valid;
            r_s1_vs.sgn   <= sgn;
            r_s1_tag      <= in_tag;
            for (int i = 0; i < ROWS; i++) begin
                r_s1_pp[i] <= w_pp[i];
            end
        end
    end

    for (genvar i = 0; i < ROWS; i++) begin : g_lvl0
        assign w_lvl[0][i] = r_s1_pp[i];
    end

    for (genvar l = 0; l < LV; l++) begin : g_lvl
        localparam int RIN = wal_rows(ROWS, l);
        localparam int NG  = RIN / 3;
        localparam int NR  = RIN % 3;
        localparam int RNX = 2 * NG + NR;

        for (genvar g = 0; g < NG; g++) begin : g_grp
            csa_row #(.W(W)) u_csa (
                .x(w_lvl[l][3*g]),
                .y(w_lvl[l][3*g+1]),
                .z(w_lvl[l][3*g+2]),
                .s(w_lvl[l+1][2*g]),
                .c(w_lvl[l+1][2*g+1])
            );
        end
        for (genvar r = 0; r < NR; r++) begin : g_pass
            assign w_lvl[l+1][2*NG+r] = w_lvl[l][3*NG+r];
        end
        for (genvar z = RNX; z < ROWS; z++) begin : g_zero
            assign w_lvl[l+1][z] = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_vs  <= '0;
            r_s2_tag <= '0;
            r_s2_sum <= '0;
            r_s2_cry <= '0;
        end else if (w_adv2) begin
            r_s2_vs  <= r_s1_vs;
            r_s2_tag <= r_s1_tag;
            r_s2_sum <= w_lvl[LV][0];
            r_s2_cry <= w_lvl[LV][1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s3_vs  <= '0;
            r_s3_tag <= '0;
            r_s3_p   <= '0;
        end else if (w_adv3) begin
            r_s3_vs  <= r_s2_vs;
            r_s3_tag <= r_s2_tag;
            r_s3_p   <= r_s2_sum + r_s2_cry;
        end
    end

endmodule
